// File: rtl/paddle_ctrl.sv
// Pong paddle controller: encoder decode, per-frame step accumulation,
// saturated position update and a CENTER/HOLD/RUN game-phase FSM.
module paddle_ctrl #(
    parameter int PMIN    = 5,
    parameter int PMAX    = 58,
    parameter int PCENTER = 28,
    parameter int ACC_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enc1a,
    input  logic       enc1b,
    input  logic       enc2a,
    input  logic       enc2b,
    input  logic       reset_game,
    input  logic       freeze,
    input  logic       tick,
    output logic [5:0] p1y,
    output logic [5:0] p2y,
    output logic       upd,
    output logic       running
);

    localparam logic [1:0] S_CENTER = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;

    localparam int AMAX = 2 ** (ACC_W - 1) - 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(AMAX);
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-AMAX);
    localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] ACC_NEG = ACC_W'(-1);
    localparam logic signed [7:0] LO = 8'(PMIN);
    localparam logic signed [7:0] HI = 8'(PMAX);
    localparam logic [5:0] PC = 6'(PCENTER);

    logic [1:0] state;
    logic [3:0] sync1, sync2, hist;
    logic [3:0] rise;
    logic up1, dn1, up2, dn2;
    logic signed [ACC_W-1:0] acc1, acc2;
    logic signed [ACC_W-1:0] step1, step2;
    logic [5:0] n1, n2;

    // Saturating single-step add; steps past the limit are dropped.
    function automatic logic signed [ACC_W-1:0] acc_add(
        input logic signed [ACC_W-1:0] a,
        input logic up,
        input logic dn
    );
        logic signed [ACC_W-1:0] r;
        r = a;
        if (up && !dn && a != ACC_MAX) r = a + ACC_ONE;
        if (dn && !up && a != ACC_MIN) r = a - ACC_ONE;
        return r;
    endfunction

    // Single step as an accumulator value, used when a tick restarts it.
    function automatic logic signed [ACC_W-1:0] step_of(
        input logic up,
        input logic dn
    );
        logic signed [ACC_W-1:0] r;
        r = '0;
        if (up && !dn) r = ACC_ONE;
        if (dn && !up) r = ACC_NEG;
        return r;
    endfunction

    // Position plus signed offset, clamped to the playfield in 8-bit signed.
    function automatic logic [5:0] apply(
        input logic [5:0] p,
        input logic signed [ACC_W-1:0] a
    );
        logic signed [7:0] sum;
        logic signed [7:0] r;
        sum = $signed({2'b00, p}) + $signed(8'(a));
        r = sum;
        if (sum < LO) r = LO;
        if (sum > HI) r = HI;
        return 6'(r);
    endfunction

    // Two-flop synchroniser followed by a history flop for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
        end else begin
            sync1 <= {enc2b, enc2a, enc1b, enc1a};
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign rise  = sync2 & ~hist;
    assign up1   = rise[0] & ~sync2[1];
    assign dn1   = rise[1] & ~sync2[0];
    assign up2   = rise[2] & ~sync2[3];
    assign dn2   = rise[3] & ~sync2[2];
    assign step1 = step_of(up1, dn1);
    assign step2 = step_of(up2, dn2);
    assign n1    = apply(p1y, acc1);
    assign n2    = apply(p2y, acc2);

    assign running = (state == S_RUN);

    // Game-phase FSM with accumulators, positions and the update pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_CENTER;
            p1y   <= PC;
            p2y   <= PC;
            acc1  <= '0;
            acc2  <= '0;
            upd   <= 1'b0;
        end else begin
            upd <= 1'b0;
            if (reset_game) begin
                state <= S_CENTER;
                p1y   <= PC;
                p2y   <= PC;
                acc1  <= '0;
                acc2  <= '0;
                upd   <= (p1y != PC) || (p2y != PC);
            end else begin
                unique case (state)
                    S_CENTER: begin
                        p1y   <= PC;
                        p2y   <= PC;
                        acc1  <= '0;
                        acc2  <= '0;
                        state <= S_HOLD;
                    end
                    S_HOLD: begin
                        acc1 <= '0;
                        acc2 <= '0;
                        if (tick && !freeze) state <= S_RUN;
                    end
                    S_RUN: begin
                        if (freeze) begin
                            state <= S_HOLD;
                            acc1  <= '0;
                            acc2  <= '0;
                        end else if (tick) begin
                            p1y  <= n1;
                            p2y  <= n2;
                            acc1 <= step1;
                            acc2 <= step2;
                            upd  <= (n1 != p1y) || (n2 != p2y);
                        end else begin
                            acc1 <= acc_add(acc1, up1, dn1);
                            acc2 <= acc_add(acc2, up2, dn2);
                        end
                    end
                    default: state <= S_CENTER;
                endcase
            end
        end
    end

endmodule
